// File: rtl/fallthrough_fifo_prog.sv
// rtl/fallthrough_fifo_prog.sv - first-word-fallthrough FIFO with programmable thresholds, count and flush
// Optional sticky overflow/underflow flags are enabled by defining FALLTHROUGH_FIFO_ERRFLAGS_EN.
module fallthrough_fifo_prog #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3,
  parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1,
  parameter int NEARLY_EMPTY   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic                      flush,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      nearly_full,
  output logic                      empty,
  output logic                      nearly_empty,
  output logic [MAX_DEPTH_BITS:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int MAX_DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int CW        = MAX_DEPTH_BITS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(MAX_DEPTH);
  localparam logic [CW-1:0] NF_C    = CW'(NEARLY_FULL);
  localparam logic [CW-1:0] NE_C    = CW'(NEARLY_EMPTY);

  typedef enum logic [1:0] {
    SEL_KEEP  = 2'd0,
    SEL_DIN   = 2'd1,
    SEL_QUEUE = 2'd2
  } dout_sel_e;

  logic [WIDTH-1:0]          mem_q [MAX_DEPTH];
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nxt;
  logic [CW-1:0]             count_q, count_d;
  logic                      empty_q, empty_d, full_q, full_d;
  logic [WIDTH-1:0]          dout_q, dout_d;
  logic                      wr_ok, rd_ok;
  dout_sel_e                 dout_sel;

  always_comb begin
    wr_ok      = wr_en & (~full_q | rd_en) & ~flush;
    rd_ok      = rd_en & ~empty_q & ~flush;
    rd_ptr_nxt = rd_ptr_q + 1'b1;

    // The new head is din when it lands in an empty FIFO or right behind the word being popped.
    if (wr_ok && (empty_q || (rd_ok && rd_ptr_nxt == wr_ptr_q))) begin
      dout_sel = SEL_DIN;
    end else if (rd_ok) begin
      dout_sel = SEL_QUEUE;
    end else begin
      dout_sel = SEL_KEEP;
    end

    case (dout_sel)
      SEL_DIN:   dout_d = din;
      SEL_QUEUE: dout_d = mem_q[rd_ptr_nxt];
      default:   dout_d = dout_q;
    endcase

    rd_ptr_d = rd_ok ? rd_ptr_nxt : rd_ptr_q;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout         = dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign count        = count_q;
  assign nearly_full  = (count_q >= NF_C);
  assign nearly_empty = (count_q <= NE_C);

`ifdef FALLTHROUGH_FIFO_ERRFLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  // Flush suppresses the access entirely, so it cannot raise either flag.
  always_comb begin
    overflow_d  = overflow_q  | (wr_en & ~flush & ~wr_ok);
    underflow_d = underflow_q | (rd_en & ~flush & ~rd_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
